// File: rtl/serializer_out_if.sv
// +----------------------------------------------------------------------------+
// | serializer_out_if : start/data request and serial line bundle, Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface serializer_out_if #(
  parameter int DataWidth = 8
);
  logic                 start_i;
  logic [DataWidth-1:0] data_i;
  logic                 data_o;
  logic                 ena_o;
  logic                 bit_strb_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i,
    output data_i,
    input  data_o,
    input  ena_o,
    input  bit_strb_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  data_i,
    output data_o,
    output ena_o,
    output bit_strb_o,
    output busy_o,
    output done_o
  );
endinterface

`default_nettype wire

// File: rtl/serializer_out.sv
// +----------------------------------------------------------------------------+
// | serializer_out : parallel-to-serial transmitter with bit hold, Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module serializer_out #(
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 4,
  parameter bit MsbFirst  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  serializer_out_if.slave bus
);

  localparam int DIV_W = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BIT_W = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ClkDiv - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DataWidth - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [DataWidth-1:0] shreg;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 data_q;
  logic                 ena_q;
  logic                 strb_q;
  logic                 busy_q;
  logic                 done_q;

  // The shift register always holds the bits still to be sent, already
  // aligned so the next one sits at the outgoing end.
  logic                 load_bit;
  logic [DataWidth-1:0] load_rem;
  logic                 head_bit;
  logic [DataWidth-1:0] shreg_nxt;

  generate
    if (MsbFirst) begin : g_msb_first
      assign load_bit  = bus.data_i[DataWidth-1];
      assign load_rem  = {bus.data_i[DataWidth-2:0], 1'b0};
      assign head_bit  = shreg[DataWidth-1];
      assign shreg_nxt = {shreg[DataWidth-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_bit  = bus.data_i[0];
      assign load_rem  = {1'b0, bus.data_i[DataWidth-1:1]};
      assign head_bit  = shreg[0];
      assign shreg_nxt = {1'b0, shreg[DataWidth-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      data_q  <= 1'b0;
      ena_q   <= 1'b0;
      strb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          strb_q <= 1'b0;
          if (bus.start_i) begin
            shreg   <= load_rem;
            div_cnt <= '0;
            bit_cnt <= '0;
            data_q  <= load_bit;
            ena_q   <= 1'b1;
            strb_q  <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              data_q <= 1'b0;
              ena_q  <= 1'b0;
              strb_q <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              shreg   <= shreg_nxt;
              bit_cnt <= bit_cnt + BIT_W'(1);
              data_q  <= head_bit;
              strb_q  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            strb_q  <= 1'b0;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_o     = data_q;
  assign bus.ena_o      = ena_q;
  assign bus.bit_strb_o = strb_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serializer_out.sv
// +----------------------------------------------------------------------------+
// | tb_serializer_out : self-checking bench for serializer_out, Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serializer_out;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  serializer_out_if #(.DataWidth(8)) if0 ();
  serializer_out_if #(.DataWidth(8)) if1 ();
  serializer_out_if #(.DataWidth(4)) if2 ();

  serializer_out #(.DataWidth(8), .ClkDiv(4), .MsbFirst(1'b1)) dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if0));
  serializer_out #(.DataWidth(8), .ClkDiv(4), .MsbFirst(1'b0)) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if1));
  serializer_out #(.DataWidth(4), .ClkDiv(1), .MsbFirst(1'b1)) dut2 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq holds the expected line bits in send order, first bit at seq[n-1]
  typedef struct {
    int         idx;
    logic [7:0] data;
    int         n;
    int         div;
    logic [7:0] seq;
    string      name;
  } vec_t;

  vec_t vecs [8];

  bit q0 [$];
  bit q1 [$];
  bit q2 [$];

  // {data, ena, strb, busy, done}
  function automatic logic [4:0] get_outs(int idx);
    case (idx)
      0:       return {if0.data_o, if0.ena_o, if0.bit_strb_o, if0.busy_o, if0.done_o};
      1:       return {if1.data_o, if1.ena_o, if1.bit_strb_o, if1.busy_o, if1.done_o};
      default: return {if2.data_o, if2.ena_o, if2.bit_strb_o, if2.busy_o, if2.done_o};
    endcase
  endfunction

  task automatic drive(int idx, logic start, logic [7:0] d);
    case (idx)
      0:       begin if0.start_i = start; if0.data_i = d;      end
      1:       begin if1.start_i = start; if1.data_i = d;      end
      default: begin if2.start_i = start; if2.data_i = d[3:0]; end
    endcase
  endtask

  task automatic push_frame(int idx, logic [7:0] seq, int n);
    for (int k = 0; k < n; k++) begin
      case (idx)
        0:       q0.push_back(seq[n-1-k]);
        1:       q1.push_back(seq[n-1-k]);
        default: q2.push_back(seq[n-1-k]);
      endcase
    end
  endtask

  task automatic chk(string name, int c, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got d/ena/strb/busy/done=%b expected %b",
               name, c, act, exp);
    end
  endtask

  // Reference timing of one frame, c counted from the accepting edge.
  task automatic check_cycle(int idx, int c, int n, int div, logic [7:0] seq, string name);
    logic [4:0] exp;
    logic       e;
    logic       b;
    logic       s;
    e = (c >= 1) && (c <= n * div);
    b = 1'b0;
    s = 1'b0;
    if (e) begin
      b = seq[n - 1 - (c - 1) / div];
      s = ((c - 1) % div) == 0;
    end
    exp = {b, e, s, e, (c == n * div + 1)};
    chk(name, c, get_outs(idx), exp);
  endtask

  task automatic run_frame(vec_t v);
    push_frame(v.idx, v.seq, v.n);
    @(posedge clk);
    #1 drive(v.idx, 1'b1, v.data);
    @(posedge clk);
    #1 drive(v.idx, 1'b0, 8'h00);
    for (int c = 1; c <= v.n * v.div + 3; c++) begin
      @(negedge clk);
      check_cycle(v.idx, c, v.n, v.div, v.seq, v.name);
    end
  endtask

  // Scoreboard: each bit strobe consumes one expected bit for that instance.
  always @(negedge clk) begin
    logic [4:0] o;
    bit         have;
    bit         expb;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        o = get_outs(i);
        if (o[3] && o[2]) begin
          have = 1'b0;
          expb = 1'b0;
          case (i)
            0:       if (q0.size() > 0) begin have = 1'b1; expb = q0.pop_front(); end
            1:       if (q1.size() > 0) begin have = 1'b1; expb = q1.pop_front(); end
            default: if (q2.size() > 0) begin have = 1'b1; expb = q2.pop_front(); end
          endcase
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d: strobe with data=%b, expected no frame", i, o[4]);
          end else if (o[4] !== expb) begin
            errors++;
            $display("FAIL sb_bit dut%0d: got %b expected %b", i, o[4], expb);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 8, 4, 8'hA5, "msb_a5"};
    vecs[1] = '{0, 8'h00, 8, 4, 8'h00, "msb_00"};
    vecs[2] = '{0, 8'h81, 8, 4, 8'h81, "msb_81"};
    vecs[3] = '{1, 8'hA5, 8, 4, 8'hA5, "lsb_a5"};
    vecs[4] = '{1, 8'h01, 8, 4, 8'h80, "lsb_01"};
    vecs[5] = '{1, 8'h3C, 8, 4, 8'h3C, "lsb_3c"};
    vecs[6] = '{2, 8'h09, 4, 1, 8'h09, "div1_9"};
    vecs[7] = '{2, 8'h06, 4, 1, 8'h06, "div1_6"};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset", 0, get_outs(i), 5'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // start held high: back-to-back frames, data_i swapped mid-frame
    push_frame(0, 8'h3C, 8);
    push_frame(0, 8'hC3, 8);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'h3C);
    @(posedge clk);
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c <= 34) check_cycle(0, c, 8, 4, 8'h3C, "b2b_f1");
      else         check_cycle(0, c - 34, 8, 4, 8'hC3, "b2b_f2");
      if (c == 20) drive(0, 1'b1, 8'hC3);
      if (c == 35) drive(0, 1'b0, 8'h00);
    end

    // data_i changes and a stray start inside a frame have no effect
    push_frame(0, 8'hFF, 8);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'hFF);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'hFF);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check_cycle(0, c, 8, 4, 8'hFF, "hold_ff");
      if (c == 2)  drive(0, 1'b0, 8'h00);
      if (c == 10) drive(0, 1'b1, 8'h00);
      if (c == 11) drive(0, 1'b0, 8'h00);
    end

    // reset in the middle of a frame
    push_frame(0, 8'h77, 8);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'h77);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check_cycle(0, c, 8, 4, 8'h77, "pre_rst");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_async", 12, get_outs(0), 5'b0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 15; c <= 40; c++) begin
      @(negedge clk);
      chk("rst_quiet", c, get_outs(0), 5'b0);
    end
    run_frame('{0, 8'h5A, 8, 4, 8'h5A, "post_rst_5a"});

    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d unsent bits expected 0",
               q0.size() + q1.size() + q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serializer_out.md
Name: serializer_out

Overview:
Parallel-to-serial transmitter. It is the transmit-side counterpart of serializer_in. On a start request it latches a DataWidth-bit word and shifts it out one bit at a time, holding each bit for a programmable number of clock cycles. It drives a frame enable, a per-bit strobe, busy and done, so a serializer_in instance or an off-chip receiver can sample the line.

Parameters:
DataWidth, 8, word width in bits (>=2)
ClkDiv, 4, clock cycles each bit is held on data_o (>=1)
MsbFirst, 1, 1 = bit DataWidth-1 goes first; 0 = bit 0 goes first

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous reset, active-low
start_i  in  1  request to transmit data_i, level-sampled
data_i  in  DataWidth  parallel word, captured on the accepting edge
data_o  out  1  serial data line
ena_o  out  1  high while a frame bit is valid on data_o
bit_strb_o  out  1  one-cycle pulse in the first cycle of each bit
busy_o  out  1  high from the accepting edge until the frame ends
done_o  out  1  one-cycle pulse after the last bit

Behaviour:
- Reset: one clock, clk_i. rst_ni is asynchronous and active-low. While rst_ni=0, all of the following are cleared immediately, independent of clk_i: state=IDLE, shift reg=0, counters=0, data_o=0, ena_o=0, bit_strb_o=0, busy_o=0, done_o=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start_i=1 at the rising edge: latch data_i into the shift register, clear the div and bit counters, go to SHIFT.
  - Otherwise stay in IDLE.
- Call the accepting edge cycle 0. Then:
  - Cycles 1..ClkDiv: ena_o=1, data_o=first bit, busy_o=1.
  - bit_strb_o=1 in cycle 1.
- SHIFT:
  - The div counter counts 0..ClkDiv-1.
  - When it wraps: shift by one bit (left if MsbFirst, else right), increment the bit counter, pulse bit_strb_o in the next cycle.
  - Bit k (k=0..DataWidth-1) occupies cycles k*ClkDiv+1 .. (k+1)*ClkDiv.
  - After the last bit's final cycle, go to DONE.
- DONE, cycle DataWidth*ClkDiv+1:
  - done_o=1, ena_o=0, busy_o=0, data_o=0.
  - Next state is IDLE unconditionally.
- data_o is a registered output, taken from the shift register end bit and gated by ena_o. It is 0 whenever ena_o=0.
- start_i is ignored in SHIFT and DONE: no queuing, no abort.
- start_i held high continuously gives back-to-back frames. Between frames there is one DONE cycle and one IDLE (accepting) cycle. Frame period = DataWidth*ClkDiv+2 cycles.
- data_i changes after the accepting edge do not affect the frame in flight.
- ClkDiv=1:
  - One cycle per bit.
  - bit_strb_o stays high for all DataWidth cycles of the frame.
- Counter widths:
  - Div counter: $clog2(ClkDiv), minimum 1 bit.
  - Bit counter: $clog2(DataWidth), minimum 1 bit.
  - No overflow is reachable.
- Reset mid-frame: outputs go low immediately. The frame is discarded and done_o is not issued. After release the block waits in IDLE for a new start_i.

Test Plan:
- Defaults, data_i=0xA5, 1-cycle start pulse -> data_o sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles over cycles 1..32. Also check: bit_strb_o at cycles 1,5,...,29; done_o=1 only at cycle 33; busy_o high cycles 1..32.
- MsbFirst=0, data_i=0xA5 -> data_o sequence 1,0,1,0,0,1,0,1 (LSB first). MsbFirst=0, data_i=0x01 -> 1 then 0 x7.
- start_i held high, data_i=0x3C then 0xC3 presented at the second accepting edge -> two frames, second accepted at cycle 34. Check: second frame's first bit at cycle 35; ena_o low exactly at cycles 33-34.
- data_i changed from 0xFF to 0x00 at cycle 2 of a 0xFF frame -> data_o stays 1 for all 32 bit cycles. start_i pulsed at cycle 10 -> ignored, no extra frame.
- rst_ni asserted at cycle 12 of a frame -> all outputs 0 in the same cycle, no done_o. After release, a 0x5A frame transmits correctly.
- ClkDiv=1, DataWidth=4, data_i=0x9 -> data_o sequence 1,0,0,1 over cycles 1-4, bit_strb_o high cycles 1-4, done_o at cycle 5.
